dm_port_arbiter: RTL and testbench

Arbitrates the single data-memory (DM) port between two requesters. The CPU requester is the pipeline EXE-stage load/store path. The DBG requester is the test/loader port that preloads or inspects DM contents. The block sits between both requesters and the DM instance, drives its memread/memwrite/addr/data_in, and stalls the pipeline while the CPU waits for the port. It also returns each requester's read data one cycle after the access is issued, matching the DM's one-cycle read latency.

---
 rtl/dm_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-requester (CPU / DBG) arbiter for the single data-memory port, with DBG lock and read-data return.
// Optional grant/conflict/stall counters are built when ARB_STATS_EN is defined.
module dm_port_arbiter #(
  parameter int DSIZE  = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DSIZE-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DSIZE-1:0]  cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_addr,
  input  logic [DSIZE-1:0]  dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DSIZE-1:0]  dbg_rdata,
  output logic              dm_memread,
  output logic              dm_memwrite,
  output logic [AWIDTH-1:0] dm_addr,
  output logic [DSIZE-1:0]  dm_data_in,
  input  logic [DSIZE-1:0]  dm_data_out
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       cpu_gnt_cnt,
  output logic [15:0]       dbg_gnt_cnt,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic {NORMAL, LOCKED} lock_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  lock_state_t      lock_state;
  owner_t           last_owner;
  owner_t           rd_owner;
  logic             rd_pend;
  logic [DSIZE-1:0] cpu_rdata_q;
  logic [DSIZE-1:0] dbg_rdata_q;
  logic             lock_active;

  // Lock only holds while dbg_lock stays high, so the release cycle is arbitrated normally.
  // Grants are masked during reset so every output reads 0 while rst is low.
  always_comb begin
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    lock_active = (lock_state == LOCKED) && dbg_lock;
    if (rst) begin
      if (lock_active) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (last_owner == OWN_DBG) cpu_gnt = 1'b1;
        else                       dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    dm_memread  = 1'b0;
    dm_memwrite = 1'b0;
    dm_addr     = '0;
    dm_data_in  = '0;
    if (cpu_gnt) begin
      dm_memread  = ~cpu_we;
      dm_memwrite = cpu_we;
      dm_addr     = cpu_addr;
      dm_data_in  = cpu_wdata;
    end else if (dbg_gnt) begin
      dm_memread  = ~dbg_we;
      dm_memwrite = dbg_we;
      dm_addr     = dbg_addr;
      dm_data_in  = dbg_wdata;
    end
  end

  assign cpu_stall  = rst & cpu_req & ~cpu_gnt;
  assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
  assign dbg_rvalid = rd_pend && (rd_owner == OWN_DBG);
  // DM data is live in the return cycle; the registers only hold it for later cycles.
  assign cpu_rdata  = cpu_rvalid ? dm_data_out : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? dm_data_out : dbg_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_state  <= NORMAL;
      last_owner  <= OWN_DBG;
      rd_owner    <= OWN_CPU;
      rd_pend     <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (lock_state == LOCKED && !dbg_lock) lock_state <= NORMAL;
      else if (dbg_gnt && dbg_lock)          lock_state <= LOCKED;

      if (cpu_gnt)      last_owner <= OWN_CPU;
      else if (dbg_gnt) last_owner <= OWN_DBG;

      rd_pend  <= (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
      rd_owner <= cpu_gnt ? OWN_CPU : OWN_DBG;

      if (cpu_rvalid) cpu_rdata_q <= dm_data_out;
      if (dbg_rvalid) dbg_rdata_q <= dm_data_out;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_gnt_cnt  <= '0;
      dbg_gnt_cnt  <= '0;
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      cpu_gnt_cnt  <= sat_inc(cpu_gnt_cnt, cpu_gnt);
      dbg_gnt_cnt  <= sat_inc(dbg_gnt_cnt, dbg_gnt);
      conflict_cnt <= sat_inc(conflict_cnt, cpu_req & dbg_req);
      stall_cnt    <= sat_inc(stall_cnt, cpu_stall);
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small one-cycle-latency DM model behind the port.
// Stats counters are checked only when ARB_STATS_EN is defined.
module tb_dm_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        dm_memread, dm_memwrite;
  logic [31:0] dm_addr, dm_data_in, dm_data_out;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt, conflict_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cpu_grants;
  int dbg_grants;

  logic [31:0] mem [0:15];

  dm_port_arbiter #(.DSIZE(32), .AWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dm_memread(dm_memread), .dm_memwrite(dm_memwrite), .dm_addr(dm_addr),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
`ifdef ARB_STATS_EN
    , .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt),
    .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM model: synchronous write, read data available the cycle after memread.
  always @(posedge clk) begin
    if (dm_memwrite) mem[dm_addr[3:0]] <= dm_data_in;
    if (dm_memread)  dm_data_out <= mem[dm_addr[3:0]];
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // New inputs one unit after the edge; outputs settle and are sampled one unit later.
  task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                                input logic [31:0] c_wdata, input logic d_req, input logic d_we,
                                input logic [31:0] d_addr, input logic [31:0] d_wdata,
                                input logic d_lock);
    @(posedge clk);
    #1;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
    dbg_lock = d_lock;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
    #2;
    check_output("reset_cpu_gnt", cpu_gnt, 0);
    check_output("reset_dbg_gnt", dbg_gnt, 0);
    check_output("reset_memread", dm_memread, 0);
    check_output("reset_cpu_rvalid", cpu_rvalid, 0);
    check_output("reset_cpu_rdata", cpu_rdata, 0);
    #1 rst = 1'b1;

    $display("[TB] preload DM through the DBG port");
    apply_stimulus(0, 0, 0, 0, 1, 1, 2, 32'hAAAA0002, 0);
    check_output("preload2_gnt", dbg_gnt, 1);
    check_output("preload2_memwrite", dm_memwrite, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 3, 32'hBBBB0003, 0);
    check_output("preload3_gnt", dbg_gnt, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 5, 32'h00001234, 0);
    check_output("preload5_data_in", dm_data_in, 32'h00001234);

    $display("[TB] tie after reset and back-to-back reads");
    do_reset();
    apply_stimulus(1, 0, 2, 0, 1, 0, 3, 0, 0);
    check_output("tie_cpu_gnt", cpu_gnt, 1);
    check_output("tie_dbg_gnt", dbg_gnt, 0);
    check_output("tie_cpu_stall", cpu_stall, 0);
    check_output("tie_dm_addr", dm_addr, 2);
    check_output("tie_memread", dm_memread, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 3, 0, 0);
    check_output("b2b_dbg_gnt", dbg_gnt, 1);
    check_output("b2b_dm_addr", dm_addr, 3);
    check_output("b2b_cpu_rvalid", cpu_rvalid, 1);
    check_output("b2b_cpu_rdata", cpu_rdata, 32'hAAAA0002);
    idle();
    check_output("b2b_dbg_rvalid", dbg_rvalid, 1);
    check_output("b2b_dbg_rdata", dbg_rdata, 32'hBBBB0003);
    check_output("b2b_cpu_rvalid_off", cpu_rvalid, 0);
    check_output("b2b_cpu_rdata_held", cpu_rdata, 32'hAAAA0002);

    $display("[TB] uncontested CPU read, then write");
    apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
    check_output("rd5_cpu_gnt", cpu_gnt, 1);
    check_output("rd5_memread", dm_memread, 1);
    check_output("rd5_dm_addr", dm_addr, 5);
    check_output("rd5_stall", cpu_stall, 0);
    idle();
    check_output("rd5_rvalid", cpu_rvalid, 1);
    check_output("rd5_rdata", cpu_rdata, 32'h00001234);
    check_output("rd5_stall_after", cpu_stall, 0);
    check_output("idle_memread", dm_memread, 0);
    check_output("idle_dm_addr", dm_addr, 0);
    apply_stimulus(1, 1, 7, 32'h000055AA, 0, 0, 0, 0, 0);
    check_output("wr7_cpu_gnt", cpu_gnt, 1);
    check_output("wr7_memwrite", dm_memwrite, 1);
    check_output("wr7_memread", dm_memread, 0);
    check_output("wr7_data_in", dm_data_in, 32'h000055AA);
    apply_stimulus(0, 0, 0, 0, 1, 0, 7, 0, 0);
    check_output("wr7_no_rvalid", cpu_rvalid, 0);
    check_output("rd7_dbg_gnt", dbg_gnt, 1);
    idle();
    check_output("rd7_dbg_rvalid", dbg_rvalid, 1);
    check_output("rd7_dbg_rdata", dbg_rdata, 32'h000055AA);

    $display("[TB] sustained contention");
    do_reset();
    cpu_grants = 0;
    dbg_grants = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1, 1, 8, i, 1, 1, 9, i, 0);
      check_output("alt_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
      check_output("alt_dbg_gnt", dbg_gnt, (i % 2 == 1) ? 1 : 0);
      cpu_grants += int'(cpu_gnt);
      dbg_grants += int'(dbg_gnt);
    end
    check_output("alt_cpu_total", cpu_grants, 5);
    check_output("alt_dbg_total", dbg_grants, 5);
`ifdef ARB_STATS_EN
    idle();
    check_output("stats_conflict", conflict_cnt, 10);
    check_output("stats_cpu_gnt", cpu_gnt_cnt, 5);
    check_output("stats_dbg_gnt", dbg_gnt_cnt, 5);
    check_output("stats_stall", stall_cnt, 5);
`endif

    $display("[TB] DBG lock");
    apply_stimulus(0, 0, 0, 0, 1, 1, 10, 32'h0000000A, 1);
    check_output("lock_dbg_gnt", dbg_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 1);
      check_output("locked_cpu_gnt", cpu_gnt, 0);
      check_output("locked_cpu_stall", cpu_stall, 1);
    end
    apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
    check_output("unlock_cpu_gnt", cpu_gnt, 1);
    check_output("unlock_cpu_stall", cpu_stall, 0);
    apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 1);
    check_output("lock_noreq_cpu_gnt0", cpu_gnt, 1);
    apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 1);
    check_output("lock_noreq_cpu_gnt1", cpu_gnt, 1);
    check_output("lock_noreq_stall", cpu_stall, 0);
    idle();
`ifdef ARB_STATS_EN
    check_output("stats_stall_lock", stall_cnt, 9);
    check_output("stats_cpu_gnt_lock", cpu_gnt_cnt, 8);
    check_output("stats_dbg_gnt_lock", dbg_gnt_cnt, 6);
`endif

    $display("[TB] reset mid-read");
    apply_stimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
    check_output("midrd_cpu_gnt", cpu_gnt, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    #1;
    check_output("midrd_rst_rvalid", cpu_rvalid, 0);
    check_output("midrd_rst_rdata", cpu_rdata, 0);
    check_output("midrd_rst_memread", dm_memread, 0);
    check_output("midrd_rst_gnt", cpu_gnt, 0);
`ifdef ARB_STATS_EN
    check_output("midrd_rst_stats", stall_cnt, 0);
`endif
    #2 rst = 1'b1;
    idle();
    check_output("midrd_post_cpu_rvalid", cpu_rvalid, 0);
    check_output("midrd_post_dbg_rvalid", dbg_rvalid, 0);
    check_output("midrd_post_rdata", cpu_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
